// File: rtl/mem_init_pkg.sv
// mem_init_pkg: shared types and default widths for the mem_init region initialiser.
//   mode_t  - pattern select (identity, constant fill, descending, xor with key)
//   state_t - sequencer states (idle, writing, completion pulse)
package mem_init_pkg;

   localparam int unsigned DefAddrW = 8;
   localparam int unsigned DefDataW = 8;

   typedef enum logic [1:0] {
      ModeIdentity = 2'd0,
      ModeFill     = 2'd1,
      ModeDescend  = 2'd2,
      ModeXorKey   = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StWrite  = 2'd1,
      StFinish = 2'd2
   } state_t;

endpackage

// File: rtl/mem_init_pattern.sv
// mem_init_pattern: combinational data generator for one RAM word.
//   mode     in  pattern select
//   idx      in  word index within the region (ADDR_W+1 bits)
//   len      in  region length (ADDR_W+1 bits)
//   fill_val in  constant used by the fill and xor-key patterns
//   wrdata   out pattern value for this index
module mem_init_pattern
   import mem_init_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned DATA_W = DefDataW
) (
   input  mode_t             mode,
   input  logic [ADDR_W:0]   idx,
   input  logic [ADDR_W:0]   len,
   input  logic [DATA_W-1:0] fill_val,
   output logic [DATA_W-1:0] wrdata
);

   localparam int unsigned IdxW = ADDR_W + 1;
   localparam logic [ADDR_W:0] LenOne = {{ADDR_W{1'b0}}, 1'b1};

   logic [ADDR_W:0]   w_desc;
   logic [DATA_W-1:0] w_idx_ext;
   logic [DATA_W-1:0] w_desc_ext;

   // Only ever evaluated with idx < len, so this never underflows in use.
   assign w_desc = len - LenOne - idx;

   // Index-derived values are zero-extended or truncated to the data width.
   if (DATA_W > IdxW) begin : g_zext
      assign w_idx_ext  = {{(DATA_W - IdxW){1'b0}}, idx};
      assign w_desc_ext = {{(DATA_W - IdxW){1'b0}}, w_desc};
   end else if (DATA_W == IdxW) begin : g_same
      assign w_idx_ext  = idx;
      assign w_desc_ext = w_desc;
   end else begin : g_trunc
      assign w_idx_ext  = idx[DATA_W-1:0];
      assign w_desc_ext = w_desc[DATA_W-1:0];
   end

   always_comb begin
      wrdata = w_idx_ext;
      case (mode)
         ModeIdentity: wrdata = w_idx_ext;
         ModeFill:     wrdata = fill_val;
         ModeDescend:  wrdata = w_desc_ext;
         ModeXorKey:   wrdata = w_idx_ext ^ fill_val;
         default:      wrdata = w_idx_ext;
      endcase
   end

endmodule

// File: rtl/mem_init.sv
// mem_init: writes a programmable pattern into a contiguous (wrapping) region of a
// single-port RAM, one word per cycle.
//   clk, rst_n          clock, asynchronous active-low reset
//   en / rdy            start request, accepted only while rdy=1
//   mode, base, len,    operation parameters, sampled together with en
//   fill_val
//   abort               cancels a run in progress (no done pulse)
//   addr, wrdata, wren  RAM write port (all registered)
//   done                one-cycle pulse on normal completion
module mem_init
   import mem_init_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned DATA_W = DefDataW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic              rdy,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   len,
   input  logic [DATA_W-1:0] fill_val,
   input  logic              abort,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wrdata,
   output logic              wren,
   output logic              done
);

   localparam logic [ADDR_W:0] LenOne = {{ADDR_W{1'b0}}, 1'b1};

   state_t            r_state;
   mode_t             r_mode;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W:0]   r_len;
   logic [DATA_W-1:0] r_fill;
   logic [ADDR_W:0]   r_idx;
   logic              r_rdy;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wrdata;
   logic              r_wren;
   logic              r_done;

   logic [DATA_W-1:0] w_pattern;
   logic [ADDR_W-1:0] w_addr_next;
   logic              w_last;

   mem_init_pattern #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pattern (
      .mode     (r_mode),
      .idx      (r_idx),
      .len      (r_len),
      .fill_val (r_fill),
      .wrdata   (w_pattern)
   );

   // Dropping the top idx bit makes base+idx wrap modulo the RAM size.
   assign w_addr_next = r_base + r_idx[ADDR_W-1:0];
   assign w_last      = (r_idx == (r_len - LenOne));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_mode   <= ModeIdentity;
         r_base   <= '0;
         r_len    <= '0;
         r_fill   <= '0;
         r_idx    <= '0;
         r_rdy    <= 1'b1;
         r_addr   <= '0;
         r_wrdata <= '0;
         r_wren   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               r_wren <= 1'b0;
               if (r_rdy && en) begin
                  r_mode  <= mode_t'(mode);
                  r_base  <= base;
                  r_len   <= len;
                  r_fill  <= fill_val;
                  r_idx   <= '0;
                  r_rdy   <= 1'b0;
                  r_state <= (len != '0) ? StWrite : StFinish;
               end else begin
                  // Re-raises rdy in the cycle after the done pulse.
                  r_rdy <= 1'b1;
               end
            end
            StWrite: begin
               if (abort) begin
                  r_wren  <= 1'b0;
                  r_rdy   <= 1'b1;
                  r_state <= StIdle;
               end else begin
                  r_wren   <= 1'b1;
                  r_addr   <= w_addr_next;
                  r_wrdata <= w_pattern;
                  r_idx    <= r_idx + LenOne;
                  if (w_last) begin
                     r_state <= StFinish;
                  end
               end
            end
            StFinish: begin
               r_wren  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= StIdle;
            end
            default: begin
               r_wren  <= 1'b0;
               r_rdy   <= 1'b1;
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign rdy    = r_rdy;
   assign addr   = r_addr;
   assign wrdata = r_wrdata;
   assign wren   = r_wren;
   assign done   = r_done;

endmodule

// File: tb/tb_mem_init.sv
// tb_mem_init: directed, table-driven bench for mem_init with a behavioural RAM.
module tb_mem_init;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam int          CapN = 300;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          rdy;
   logic [1:0]    mode = 2'd0;
   logic [AW-1:0] base = '0;
   logic [AW:0]   len = '0;
   logic [DW-1:0] fill_val = '0;
   logic          abort = 1'b0;
   logic [AW-1:0] addr;
   logic [DW-1:0] wrdata;
   logic          wren;
   logic          done;

   mem_init #(
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .rdy      (rdy),
      .mode     (mode),
      .base     (base),
      .len      (len),
      .fill_val (fill_val),
      .abort    (abort),
      .addr     (addr),
      .wrdata   (wrdata),
      .wren     (wren),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Behavioural RAM; ram_clr preloads a recognisable background.
   logic [7:0] ram     [256];
   logic [7:0] exp_ram [256];
   logic       ram_clr = 1'b0;

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
      end else if (wren) begin
         ram[addr] <= wrdata;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input logic [1:0] m, input int idx, input int l,
                                      input logic [7:0] f);
      case (m)
         2'd0:    pat = 8'(idx);
         2'd1:    pat = f;
         2'd2:    pat = 8'(l - 1 - idx);
         default: pat = 8'(idx) ^ f;
      endcase
   endfunction

   task automatic model_write(input logic [1:0] m, input logic [7:0] b, input int l,
                              input logic [7:0] f);
      for (int i = 0; i < l; i++) exp_ram[(int'(b) + i) % 256] = pat(m, i, l, f);
   endtask

   task automatic check_ram(input string name);
      int nbad;
      nbad = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) nbad++;
      check(name, nbad, 0);
   endtask

   // Per-cycle capture, index c = cycles after the edge that sampled en.
   logic       cw  [CapN];
   logic [7:0] ca  [CapN];
   logic [7:0] cd  [CapN];
   logic       cdn [CapN];
   logic       crd [CapN];

   task automatic capture(input int first, input int last);
      for (int c = first; c <= last; c++) begin
         @(posedge clk);
         #1;
         cw[c]  = wren;
         ca[c]  = addr;
         cd[c]  = wrdata;
         cdn[c] = done;
         crd[c] = rdy;
      end
   endtask

   task automatic launch(input logic [1:0] m, input logic [7:0] b, input logic [8:0] l,
                         input logic [7:0] f, input logic ab);
      @(negedge clk);
      en       = 1'b1;
      mode     = m;
      base     = b;
      len      = l;
      fill_val = f;
      abort    = ab;
      @(posedge clk);
      #1;
      en    = 1'b0;
      abort = 1'b0;
   endtask

   typedef struct packed {
      logic [1:0] m;
      logic [7:0] b;
      logic [8:0] l;
      logic [7:0] f;
      logic [7:0] fa;  // first write address
      logic [7:0] fd;  // first write data
      logic [7:0] la;  // last write address
      logic [7:0] ld;  // last write data
   } vec_t;

   vec_t vecs [8];

   task automatic run_vec(input int id, input vec_t v, input logic ab);
      int n, nwr, fw, lw, nd, dc, rc;
      string p;
      p   = $sformatf("v%0d_", id);
      n   = int'(v.l) + 8;
      nwr = 0; fw = -1; lw = -1; nd = 0; dc = -1; rc = -1;
      launch(v.m, v.b, v.l, v.f, ab);
      capture(1, n);
      for (int c = 1; c <= n; c++) begin
         if (cw[c]) begin
            nwr++;
            if (fw < 0) fw = c;
            lw = c;
         end
         if (cdn[c]) begin
            nd++;
            if (dc < 0) dc = c;
         end
         if (crd[c] && rc < 0) rc = c;
      end
      check({p, "nwr"}, nwr, int'(v.l));
      check({p, "done_cyc"}, dc, int'(v.l) + 1);
      check({p, "done_cnt"}, nd, 1);
      check({p, "rdy_cyc"}, rc, int'(v.l) + 2);
      if (v.l != 0) begin
         check({p, "first_cyc"}, fw, 1);
         check({p, "last_cyc"}, lw, int'(v.l));
         if (fw > 0) begin
            check({p, "first_addr"}, ca[fw], v.fa);
            check({p, "first_data"}, cd[fw], v.fd);
            check({p, "last_addr"}, ca[lw], v.la);
            check({p, "last_data"}, cd[lw], v.ld);
         end
      end
      model_write(v.m, v.b, int'(v.l), v.f);
      check_ram({p, "ram"});
   endtask

   initial begin
      int nwr, nd;

      for (int i = 0; i < 256; i++) exp_ram[i] = 8'(i) ^ 8'h5A;
      ram_clr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdy", rdy, 1);
      check("rst_wren", wren, 0);
      check("rst_addr", addr, 0);
      check("rst_wrdata", wrdata, 0);
      check("rst_done", done, 0);
      ram_clr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_rdy", rdy, 1);

      //          mode   base    len      fill   fa     fd     la     ld
      vecs[0] = {2'd0, 8'h00, 9'd256, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
      vecs[1] = {2'd1, 8'hFE, 9'd4,   8'hA5, 8'hFE, 8'hA5, 8'h01, 8'hA5};
      vecs[2] = {2'd2, 8'h10, 9'd5,   8'h00, 8'h10, 8'h04, 8'h14, 8'h00};
      vecs[3] = {2'd3, 8'h20, 9'd3,   8'h0F, 8'h20, 8'h0F, 8'h22, 8'h0D};
      vecs[4] = {2'd0, 8'h77, 9'd0,   8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[5] = {2'd0, 8'hF0, 9'd32,  8'h00, 8'hF0, 8'h00, 8'h0F, 8'h1F};
      vecs[6] = {2'd2, 8'h00, 9'd256, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
      vecs[7] = {2'd3, 8'h80, 9'd2,   8'hFF, 8'h80, 8'hFF, 8'h81, 8'hFE};

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i], 1'b0);

      // en and abort together in idle: the run must proceed normally.
      run_vec(8, {2'd1, 8'h40, 9'd3, 8'h3C, 8'h40, 8'h3C, 8'h42, 8'h3C}, 1'b1);

      // Abort during the 10th write of a full identity run.
      launch(2'd0, 8'h00, 9'd256, 8'h00, 1'b0);
      capture(1, 10);
      check("abort_w10_wren", cw[10], 1);
      check("abort_w10_addr", ca[10], 8'h09);
      abort = 1'b1;
      capture(11, 11);
      abort = 1'b0;
      check("abort_wren", cw[11], 0);
      check("abort_rdy", crd[11], 1);
      check("abort_done", cdn[11], 0);
      capture(12, 20);
      nwr = 0;
      nd  = 0;
      for (int c = 12; c <= 20; c++) begin
         if (cw[c]) nwr++;
         if (cdn[c]) nd++;
      end
      check("abort_no_wren", nwr, 0);
      check("abort_no_done", nd, 0);
      model_write(2'd0, 8'h00, 10, 8'h00);
      check_ram("abort_ram");
      run_vec(9, {2'd3, 8'h05, 9'd3, 8'hF0, 8'h05, 8'hF0, 8'h07, 8'hF2}, 1'b0);

      // Asynchronous reset between edges in the middle of a run.
      launch(2'd0, 8'h40, 9'd100, 8'h00, 1'b0);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rstmid_wren", wren, 0);
      check("rstmid_rdy", rdy, 1);
      check("rstmid_addr", addr, 0);
      check("rstmid_done", done, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      capture(1, 4);
      check("rstmid_after_wren", cw[1] | cw[2] | cw[3] | cw[4], 0);
      check("rstmid_after_rdy", crd[4], 1);
      model_write(2'd0, 8'h40, 4, 8'h00);
      check_ram("rstmid_ram");

      // Busy-time input changes are ignored; en held into the first rdy cycle
      // starts the second run back to back.
      @(negedge clk);
      en       = 1'b1;
      mode     = 2'd1;
      base     = 8'h30;
      len      = 9'd3;
      fill_val = 8'h11;
      @(posedge clk);
      #1;
      mode     = 2'd3;
      base     = 8'h60;
      len      = 9'd2;
      fill_val = 8'h33;
      capture(1, 6);
      en = 1'b0;
      capture(7, 12);
      check("b2b_w1_addr", ca[1], 8'h30);
      check("b2b_w1_data", cd[1], 8'h11);
      check("b2b_w3_addr", ca[3], 8'h32);
      check("b2b_w3_data", cd[3], 8'h11);
      check("b2b_done1", cdn[4], 1);
      check("b2b_done1_width", cdn[5], 0);
      check("b2b_rdy1", {crd[4], crd[5]}, 2'b01);
      check("b2b_w7_addr", ca[7], 8'h60);
      check("b2b_w7_data", cd[7], 8'h33);
      check("b2b_w8_addr", ca[8], 8'h61);
      check("b2b_w8_data", cd[8], 8'h32);
      check("b2b_done2", cdn[9], 1);
      check("b2b_rdy2", crd[10], 1);
      nwr = 0;
      for (int c = 1; c <= 12; c++) if (cw[c]) nwr++;
      check("b2b_nwr", nwr, 5);
      model_write(2'd1, 8'h30, 3, 8'h11);
      model_write(2'd3, 8'h60, 2, 8'h33);
      check_ram("b2b_ram");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running, required finished");
      $fatal(1, "timeout");
   end

endmodule
